// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - operand/result bus between a requester and alu_sequencer
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [2:0]       operation;
  logic             enable;
  logic [WIDTH-1:0] rezult;
  logic             carry;
  logic             zero;
  logic             error;
  logic             busy;
  logic             done;

  modport master (
    output operand_a, operand_b, operation, enable,
    input  rezult, carry, zero, error, busy, done
  );

  modport slave (
    input  operand_a, operand_b, operation, enable,
    output rezult, carry, zero, error, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - enable-strobed ALU sequenced by a small FSM
// Defining ALU_SEQ_MUL_EN adds op 100 as a WIDTH-cycle shift-add multiply.
module alu_sequencer #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic            clock,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam int         CNT_W  = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [2:0]             op_q, op_d;
  logic [WIDTH-1:0]       rezult_q, rezult_d;
  logic                   carry_q, carry_d;
  logic                   zero_q, zero_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   start;
  logic                   legal;
  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
`ifdef ALU_SEQ_MUL_EN
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     mcand;
`endif

  // The edge flop idles high like the synchroniser, so only a real 1->0 starts.
  assign start = edge_q & ~sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.enable};
    edge_d   = sync_q[SYNC_STAGES-1];
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rezult_d = rezult_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    error_d  = error_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    legal    = 1'b1;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
`ifdef ALU_SEQ_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand    = {{WIDTH{1'b0}}, a_q} << cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = bus.operand_a;
          b_d    = bus.operand_b;
          op_d   = bus.operation;
          busy_d = 1'b1;
          state_d = EXEC;
`ifdef ALU_SEQ_MUL_EN
          if (bus.operation == OP_MUL) begin
            state_d = MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end
`endif
        end
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_ADD: begin rezult_d = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  end
          OP_SUB: begin rezult_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
          OP_AND: begin rezult_d = a_q & b_q;       carry_d = 1'b0;        end
          OP_OR:  begin rezult_d = a_q | b_q;       carry_d = 1'b0;        end
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: begin
            rezult_d = acc_q[WIDTH-1:0];
            carry_d  = |acc_q[2*WIDTH-1:WIDTH];
          end
`endif
          default: legal = 1'b0;
        endcase
        error_d = ~legal;
        if (legal) begin
          zero_d = (rezult_d == '0);
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        // b is consumed LSB first; its copy is not needed after the multiply.
        if (b_q[0]) begin
          acc_d = acc_q + mcand;
        end
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = EXEC;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sync_q   <= '1;
      edge_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rezult_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      edge_q   <= edge_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rezult_q <= rezult_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign bus.rezult = rezult_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.error  = error_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Parametrised successor to the fixed 4-bit switch-driven CPU datapath.
- Takes two WIDTH-bit operands and a 3-bit operation code.
- Starts an operation on each falling edge of the active-low `enable` strobe, which is synchronised internally.
- Runs the operation through a small FSM and returns a registered result, flags and a busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- SYNC_STAGES, 2, synchroniser flops on `enable` (≥2).

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- operand_a  input  WIDTH  first operand; sampled only at start accept.
- operand_b  input  WIDTH  second operand; sampled only at start accept.
- operation  input  3  op code; sampled only at start accept.
- enable  input  1  active-low start strobe, asynchronous to clock (switch/button).
- rezult  output  WIDTH  registered result.
- carry  output  1  carry / borrow / overflow flag.
- zero  output  1  high when `rezult` is 0.
- error  output  1  last op code was illegal.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: `reset_n` low clears all of the following asynchronously, regardless of state:
  - outputs `rezult`, `carry`, `zero`, `error`, `busy`, `done` go to 0;
  - FSM goes to IDLE; multiply counter and accumulator go to 0;
  - synchroniser flops and edge-detect flop are set to 1 (idle-high), so no spurious start occurs after reset.
- Start detect:
  - `enable` passes through SYNC_STAGES flops.
  - A start is a synchronised 1→0 transition.
  - The start is accepted only in IDLE; starts seen in any other state are dropped, not queued.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - On start accept (edge N): latch `operand_a`, `operand_b` and `operation`; set `busy`=1.
  - Go to MUL if op=100 and multiply is compiled in; otherwise go to EXEC.
- EXEC (edge N+1): compute and register `rezult`, `carry`, `zero`, `error`; go to DONE.
- DONE (edge N+2): `done`=1 for exactly one cycle; `busy`=0; go to IDLE.
- Op codes (all arithmetic modulo 2^WIDTH):
  - 000 ADD: `rezult`=A+B; `carry`=carry-out.
  - 001 SUB: `rezult`=A−B; `carry`=borrow (1 iff A<B).
  - 010 AND: `carry`=0.
  - 011 OR: `carry`=0.
  - 100 MUL: see Optional Feature.
  - 101–111 illegal: `rezult`, `carry`, `zero` unchanged; `error`=1; `done` still pulses.
- `error` is cleared by the next legal op.
- `zero` is recomputed on every legal op from the new `rezult`.
- Latency from accept to `done` high:
  - ALU ops and illegal ops: 2 cycles.
  - MUL: WIDTH+2 cycles.
- Outputs hold their values between operations.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - Op 100 is an unsigned shift-add multiply.
  - MUL state iterates once per bit of B, LSB first, using a log2(WIDTH)+1-bit counter; exactly WIDTH cycles in MUL.
  - The internal accumulator is 2·WIDTH bits.
  - On leaving MUL: `rezult`=low WIDTH bits; `carry`=OR of the high WIDTH bits (overflow).
  - Then go to DONE via an EXEC-equivalent flag update.
- Not defined:
  - MUL state, counter and accumulator are absent.
  - Op 100 is treated as illegal (`error`=1, 2-cycle latency).

Test Plan (WIDTH=4, SYNC_STAGES=2):
- Reset: assert `reset_n`=0 with `enable`=1 → all outputs 0. Release reset, hold `enable`=1 for 10 cycles → `busy` and `done` never assert.
- ADD: A=7, B=0, op=000, `enable` 1→0→1 → `rezult`=7, `carry`=0, `zero`=0, `done` pulses once, exactly 2 cycles after `busy` rises. Then A=9, B=9 → `rezult`=2, `carry`=1.
- SUB/AND/OR:
  - A=15, B=12, op=001 → 3, `carry`=0.
  - A=3, B=5, op=001 → 14, `carry`=1.
  - A=5, B=10, op=010 → 0, `zero`=1.
  - Same operands, op=011 → 15, `zero`=0.
- MUL with ALU_SEQ_MUL_EN:
  - A=5, B=3, op=100 → `busy` high 6 cycles, `rezult`=15, `carry`=0.
  - A=5, B=4 → `rezult`=4, `carry`=1.
  - Same stimulus without the macro → `error`=1, `rezult` unchanged.
- Illegal op then recovery: op=111 → `error`=1, `done` pulses. Next ADD A=1, B=1 → `rezult`=2, `error`=0.
- Abuse:
  - Second `enable` pulse while `busy` → ignored; exactly one `done`.
  - `reset_n` pulsed low mid-MUL → all outputs 0, FSM IDLE; a following ADD completes normally.
